// File: rtl/fnd_pkg.sv
// Shared FND bus constants: 7-seg patterns (same table as the fnd_controller encoder),
// bus widths and the decode result type.
package fnd_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int COM_W      = 4;
    localparam int DATA_W     = 8;
    localparam int SEG_W      = 7;
    localparam int DIG_W      = 4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [COM_W-1:0]  COM_IDLE  = 4'hF;
    localparam logic [DATA_W-1:0] DATA_IDLE = 8'hFF;
    localparam logic [DIG_W-1:0]  DIG_BLANK = 4'hE;
    localparam logic [DIG_W-1:0]  DIG_ERR   = 4'hF;

    typedef struct packed {
        logic [COM_W-1:0]  com;
        logic [DATA_W-1:0] data;
    } fnd_bus_t;

    typedef struct packed {
        logic [DIG_W-1:0] bcd;
        logic             blank;
        logic             err;
    } seg_dec_t;
endpackage

// File: rtl/fnd_scan_decoder_if.sv
// Scanned FND bus in, decoded frame/status out. master = bus driver / monitor consumer.
interface fnd_scan_decoder_if;
    import fnd_pkg::*;
    logic [COM_W-1:0]                 fnd_com;
    logic [DATA_W-1:0]                fnd_data;
    logic [NUM_DIGITS*DIG_W-1:0]      digits;
    logic [NUM_DIGITS-1:0]            dp;
    logic                             frame_valid;
    logic                             seg_err;
    logic                             com_err;
    logic                             stale;

    modport master (output fnd_com, fnd_data,
                    input  digits, dp, frame_valid, seg_err, com_err, stale);
    modport slave  (input  fnd_com, fnd_data,
                    output digits, dp, frame_valid, seg_err, com_err, stale);
endinterface

// File: rtl/fnd_seg_decode.sv
// Combinational 7-seg (active-low) to BCD decode; blank -> DIG_BLANK, unknown -> DIG_ERR.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output seg_dec_t         dec
);
    always_comb begin
        dec = '0;
        case (seg)
            SEG_0:     dec.bcd = 4'd0;
            SEG_1:     dec.bcd = 4'd1;
            SEG_2:     dec.bcd = 4'd2;
            SEG_3:     dec.bcd = 4'd3;
            SEG_4:     dec.bcd = 4'd4;
            SEG_5:     dec.bcd = 4'd5;
            SEG_6:     dec.bcd = 4'd6;
            SEG_7:     dec.bcd = 4'd7;
            SEG_8:     dec.bcd = 4'd8;
            SEG_9:     dec.bcd = 4'd9;
            SEG_BLANK: begin dec.bcd = DIG_BLANK; dec.blank = 1'b1; end
            default:   begin dec.bcd = DIG_ERR;   dec.err   = 1'b1; end
        endcase
    end
endmodule

// File: rtl/fnd_scan_decoder.sv
// Receives the multiplexed FND bus: sync, stability filter, per-digit decode into a shadow
// frame, publish on completion, and a stale-frame timer.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    fnd_scan_decoder_if.slave  bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_STB = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(FRAME_TIMEOUT);
    localparam fnd_bus_t BUS_IDLE = '{com: COM_IDLE, data: DATA_IDLE};

    fnd_bus_t [1:0]                         sync_q, sync_d;
    fnd_bus_t                               prev_q, prev_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [TMR_W-1:0]                       timer_q, timer_d;
    logic [NUM_DIGITS-1:0][DIG_W-1:0]       shadow_q, shadow_d, digits_q, digits_d;
    logic [NUM_DIGITS-1:0]                  shadow_dp_q, shadow_dp_d, dp_q, dp_d;
    logic [NUM_DIGITS-1:0]                  mask_q, mask_d;
    logic                                   frame_valid_q, frame_valid_d;
    logic                                   seg_err_q, seg_err_d, com_err_q, com_err_d;

    logic                  strobe;
    logic [COM_W-1:0]      sel;
    seg_dec_t              dec;

    // prev_q holds the value the stability window was measured on, so decode uses it
    assign strobe = (cnt_q == CNT_STB);
    assign sel    = ~prev_q.com;

    fnd_seg_decode u_dec (.seg(prev_q.data[SEG_W-1:0]), .dec(dec));

    always_comb begin
        sync_d        = {sync_q[0], fnd_bus_t'({bus.fnd_com, bus.fnd_data})};
        prev_d        = sync_q[1];
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        shadow_dp_d   = shadow_dp_q;
        mask_d        = mask_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        frame_valid_d = 1'b0;
        seg_err_d     = 1'b0;
        com_err_d     = 1'b0;
        timer_d       = timer_q;

        if (sync_q[1] != prev_q)  cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);

        if (strobe && prev_q.com != COM_IDLE) begin
            if (!$onehot(sel)) begin
                com_err_d = 1'b1;
            end else begin
                seg_err_d = dec.err && !dec.blank;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        shadow_d[i]    = dec.bcd;
                        shadow_dp_d[i] = ~prev_q.data[DATA_W-1];
                    end
                end
                mask_d = mask_q | sel;
                // Publish includes the digit written on this same edge
                if (&mask_d) begin
                    digits_d      = shadow_d;
                    dp_d          = shadow_dp_d;
                    frame_valid_d = 1'b1;
                    mask_d        = '0;
                end
            end
        end

        if (frame_valid_d)         timer_d = '0;
        else if (timer_q != TMR_MAX) timer_d = timer_q + TMR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= {BUS_IDLE, BUS_IDLE};
            prev_q        <= BUS_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            mask_q        <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            com_err_q     <= 1'b0;
            timer_q       <= '0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            com_err_q     <= com_err_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.com_err     = com_err_q;
    assign bus.stale       = (timer_q == TMR_MAX);
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench: expected frames queued at stimulus time, popped on frame_valid.
module tb_fnd_scan_decoder;
    import fnd_pkg::*;
    localparam int STABLE = 4;
    localparam int TOUT   = 100;
    localparam int HOLD   = 20;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    fnd_scan_decoder_if bus_if();

    fnd_scan_decoder #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    frame_t sb_q[$];
    int n_cmp = 0, n_mis = 0;
    int n_frames = 0, n_seg = 0, n_com = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: counts pulses, compares published frames against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.seg_err) n_seg++;
            if (bus_if.com_err) n_com++;
            if (bus_if.frame_valid) begin
                frame_t e;
                n_frames++;
                if (sb_q.size() == 0) begin
                    chk("frame_unexpected", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("frame_digits", 32'(bus_if.digits), 32'(e.digits));
                    chk("frame_dp",     32'(bus_if.dp),     32'(e.dp));
                end
            end
        end
    end

    task automatic hold(input logic [3:0] com, input logic [7:0] data, input int n);
        bus_if.fnd_com  = com;
        bus_if.fnd_data = data;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        hold(4'hE, d0, HOLD);
        hold(4'hD, d1, HOLD);
        hold(4'hB, d2, HOLD);
        hold(4'h7, d3, HOLD);
        hold(COM_IDLE, 8'hFF, 10);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_digits"}, 32'(bus_if.digits),      32'd0);
        chk({tag, "_dp"},     32'(bus_if.dp),          32'd0);
        chk({tag, "_fv"},     32'(bus_if.frame_valid), 32'd0);
        chk({tag, "_segerr"}, 32'(bus_if.seg_err),     32'd0);
        chk({tag, "_comerr"}, 32'(bus_if.com_err),     32'd0);
        chk({tag, "_stale"},  32'(bus_if.stale),       32'd0);
    endtask

    // Drives digit 3 and returns the number of negedges until frame_valid is seen
    task automatic last_digit_wait(input logic [7:0] d3, output int k);
        bus_if.fnd_com  = 4'h7;
        bus_if.fnd_data = d3;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.frame_valid && k < 50);
    endtask

    initial begin
        int f, k;
        bus_if.fnd_com  = COM_IDLE;
        bus_if.fnd_data = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        reset = 1'b0;
        hold(COM_IDLE, 8'hFF, 10);

        // Plain frame 3210
        f = n_frames;
        sb_q.push_back('{digits: 16'h3210, dp: 4'h0});
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        chk("t1_frames", 32'(n_frames), 32'(f + 1));
        chk("t1_segerr", 32'(n_seg), 32'd0);
        chk("t1_comerr", 32'(n_com), 32'd0);

        // dp on digit 2, plus a short glitch carrying digit-1 data on digit 0
        f = n_frames;
        sb_q.push_back('{digits: 16'h3210, dp: 4'b0100});
        hold(4'hE, 8'hC0, HOLD);
        hold(4'hE, 8'hF9, 2);
        hold(4'hD, 8'hF9, HOLD);
        hold(4'hB, 8'h24, HOLD);
        hold(4'h7, 8'hB0, HOLD);
        hold(COM_IDLE, 8'hFF, 10);
        chk("t2_frames", 32'(n_frames), 32'(f + 1));

        // Bad pattern on digit 1, then blank on digit 3
        f = n_frames;
        sb_q.push_back('{digits: 16'h32F0, dp: 4'h0});
        scan(8'hC0, 8'hD5, 8'hA4, 8'hB0);
        chk("t3_segerr", 32'(n_seg), 32'd1);
        sb_q.push_back('{digits: 16'hE210, dp: 4'h0});
        scan(8'hC0, 8'hF9, 8'hA4, 8'hFF);
        chk("t3_frames", 32'(n_frames), 32'(f + 2));
        chk("t3_blank_noerr", 32'(n_seg), 32'd1);

        // Two digits enabled: com_err, no mask bits set
        f = n_frames;
        hold(4'hC, 8'hC0, HOLD);
        chk("t4_comerr", 32'(n_com), 32'd1);
        hold(4'hD, 8'hF9, HOLD);
        hold(4'hB, 8'hA4, HOLD);
        hold(4'h7, 8'hB0, HOLD);
        hold(COM_IDLE, 8'hFF, 10);
        chk("t4_mask_unchanged", 32'(n_frames), 32'(f));
        sb_q.push_back('{digits: 16'h3210, dp: 4'h0});
        hold(4'hE, 8'hC0, HOLD);
        hold(COM_IDLE, 8'hFF, 100);
        chk("t4_frame_done", 32'(n_frames), 32'(f + 1));
        chk("t4_idle_comerr", 32'(n_com), 32'd1);
        chk("t4_idle_segerr", 32'(n_seg), 32'd1);

        // Latency and stale timer
        sb_q.push_back('{digits: 16'h3210, dp: 4'h0});
        hold(4'hE, 8'hC0, HOLD);
        hold(4'hD, 8'hF9, HOLD);
        hold(4'hB, 8'hA4, HOLD);
        last_digit_wait(8'hB0, k);
        chk("fv_latency", 32'(k), 32'(STABLE + 3));
        chk("stale_after_fv", 32'(bus_if.stale), 32'd0);
        bus_if.fnd_com  = COM_IDLE;
        bus_if.fnd_data = 8'hFF;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.stale && k < 2 * TOUT);
        chk("stale_latency", 32'(k), 32'(TOUT));
        hold(COM_IDLE, 8'hFF, 5);
        chk("stale_hold", 32'(bus_if.stale), 32'd1);
        sb_q.push_back('{digits: 16'h9876, dp: 4'b1000});
        hold(4'hE, 8'h82, HOLD);
        hold(4'hD, 8'hF8, HOLD);
        hold(4'hB, 8'h80, HOLD);
        last_digit_wait(8'h10, k);
        chk("fv_seen", 32'(bus_if.frame_valid), 32'd1);
        chk("stale_clear", 32'(bus_if.stale), 32'd0);
        hold(COM_IDLE, 8'hFF, 10);

        // Reset mid-frame discards digits 0,1
        hold(4'hE, 8'hC0, HOLD);
        hold(4'hD, 8'hF9, HOLD);
        reset = 1'b1;
        hold(4'hD, 8'hF9, 2);
        check_reset_outputs("rst1");
        reset = 1'b0;
        f = n_frames;
        hold(4'hB, 8'hA4, HOLD);
        hold(4'h7, 8'hB0, HOLD);
        hold(COM_IDLE, 8'hFF, 20);
        chk("t6_no_partial", 32'(n_frames), 32'(f));
        sb_q.push_back('{digits: 16'h3210, dp: 4'h0});
        hold(4'hE, 8'hC0, HOLD);
        hold(4'hD, 8'hF9, HOLD);
        hold(COM_IDLE, 8'hFF, 20);
        chk("t6_frame", 32'(n_frames), 32'(f + 1));

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
